// File: rtl/alu_issue.sv
// alu_issue: registered ALU-control decode and operand-issue stage.
// Decoded fields are mapped to an ALU op code. Operand B is selected on the
// input side. The resulting entry then passes through a two-entry valid/ready
// skid buffer to the ALU. Unsupported encodings are issued as the invalid code
// and flagged. A saturating counter tracks how many of them were handed off.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_ctl,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        alu_src,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] in_a,
  output logic [31:0] in_b,
  output logic        illegal,
  output logic [7:0]  illegal_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_INV = 4'b1111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } entry_t;

  state_t     state;
  entry_t     out_reg;
  entry_t     skid_reg;
  entry_t     dec;
  logic [3:0] dec_op;
  logic       accept;
  logic       handoff;

  // Ready depends only on registered state, never on out_ready; held low in reset.
  assign in_ready = rst_n && (state != FULL);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  assign alu_op  = out_reg.op;
  assign in_a    = out_reg.a;
  assign in_b    = out_reg.b;
  assign illegal = out_reg.ill;

  // Map the control class and funct fields onto an ALU op code.
  // For I-type, bit 30 is part of the immediate, so it does not select SUB.
  always_comb begin
    dec_op = OP_INV;
    case (alu_ctl)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec_op = funct7_5 ? OP_SUB : OP_ADD;
          3'b111:  dec_op = funct7_5 ? OP_INV : OP_AND;
          3'b110:  dec_op = funct7_5 ? OP_INV : OP_OR;
          default: dec_op = OP_INV;
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_INV;
        endcase
      end
    endcase
  end

  // Assemble the candidate entry, including the operand-B selection.
  always_comb begin
    dec     = '0;
    dec.op  = dec_op;
    dec.a   = rs1_data;
    dec.b   = alu_src ? imm : rs2_data;
    dec.ill = (dec_op == OP_INV);
  end

  // Skid-buffer state machine: output register first, skid register only under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_reg   <= dec;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && handoff) begin
            out_reg <= dec;
          end else if (accept) begin
            skid_reg <= dec;
            state    <= FULL;
          end else if (handoff) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (handoff) begin
            out_reg <= skid_reg;
            state   <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

  // Count illegal ops that are actually handed off, saturating at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_count <= 8'd0;
    end else if (handoff && out_reg.ill && (illegal_count != 8'hff)) begin
      illegal_count <= illegal_count + 8'd1;
    end
  end

endmodule
